// File: rtl/sma_pkg.sv
// Shared types and helpers for the multi-channel moving average.
// Window clamp, accumulator sizing and the pipeline stage record.
package sma_pkg;

  localparam int unsigned SMA_DATA_W = 32;
  localparam int unsigned SMA_CH_W   = 2;

  function automatic int unsigned clamp_log2(
    input logic [31:0] sel,
    input int unsigned max_l
  );
    return (sel > max_l) ? max_l : sel;
  endfunction

  function automatic int unsigned acc_w(
    input int unsigned data_w,
    input int unsigned max_l
  );
    return data_w + max_l;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [SMA_CH_W-1:0]   ch;
    logic [SMA_DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/sma_ring_ram.sv
// Simple dual-port sample ring for all channels.
// Registered read; a same-address write returns the old word.
module sma_ring_ram
  import sma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 192,
  parameter int AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write and read share the edge; the read sees pre-write contents.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/sma_mc.sv
// Time-multiplexed moving average over NUM_CH channels.
// Stage A writes/reads the ring, stage B updates sum and count.
module sma_mc
  import sma_pkg::*;
#(
  parameter  int DATA_W       = 32,
  parameter  int NUM_CH       = 3,
  parameter  int MAX_LOG2_WIN = 6,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_update_strobe,
  input  logic [CH_W-1:0]          i_ch,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic [31:0]              i_window_sel,
  input  logic                     i_clear,
  output logic                     o_valid,
  output logic [CH_W-1:0]          o_ch,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_full,
  output logic [15:0]              m_count,
  output logic signed [63:0]       m_sum
);

  localparam int ACC_W = int'(acc_w(DATA_W, MAX_LOG2_WIN));
  localparam int LW    = $clog2(MAX_LOG2_WIN + 1);
  localparam int PTR_W = MAX_LOG2_WIN;
  localparam int CNT_W = MAX_LOG2_WIN + 1;
  localparam int AW    = CH_W + PTR_W;
  localparam int DEPTH = NUM_CH << PTR_W;

  logic [LW-1:0] sel_q, sel_d, sel_new;
  logic [CNT_W-1:0] n_cur;
  logic flush, ch_ok, accept;
  logic [CH_W-1:0] ch_a;
  logic [AW-1:0] waddr, raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic [PTR_W-1:0] wptr_q [NUM_CH];
  logic [PTR_W-1:0] wptr_d [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [CNT_W-1:0] count_d [NUM_CH];
  logic signed [ACC_W-1:0] sum_q [NUM_CH];
  logic signed [ACC_W-1:0] sum_d [NUM_CH];

  stage_t sa_q, sa_d;

  logic [CH_W-1:0] chb;
  logic signed [DATA_W-1:0] x_b, old_b;
  logic signed [ACC_W-1:0] x_e, old_e, sum_b, sum_n, avg;
  logic [CNT_W-1:0] cnt_b, cnt_n;
  logic win_full;

  logic o_valid_q, o_valid_d;
  logic [CH_W-1:0] o_ch_q, o_ch_d;
  logic signed [DATA_W-1:0] o_data_q, o_data_d;
  logic o_full_q, o_full_d;
  logic [15:0] m_count_q, m_count_d;
  logic signed [63:0] m_sum_q, m_sum_d;

  // Window selection, flush detection and stage A acceptance.
  always_comb begin
    sel_new = LW'(clamp_log2(i_window_sel, MAX_LOG2_WIN));
    sel_d   = sel_new;
    n_cur   = CNT_W'(1) << sel_q;
    flush   = i_clear | (sel_new != sel_q);
    ch_ok   = 32'(i_ch) < 32'(NUM_CH);
    ch_a    = ch_ok ? i_ch : '0;
    accept  = i_update_strobe & ch_ok & ~flush;
    waddr   = {ch_a, wptr_q[ch_a]};
    raddr   = {ch_a, wptr_q[ch_a] - PTR_W'(n_cur)};
    sa_d        = '0;
    sa_d.valid  = accept;
    sa_d.ch     = SMA_CH_W'(ch_a);
    sa_d.data   = SMA_DATA_W'(i_data);
  end

  sma_ring_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (accept),
    .i_waddr (waddr),
    .i_wdata (i_data),
    .i_raddr (raddr),
    .o_rdata (ram_rdata)
  );

  // Stage B arithmetic: slide the window sum and saturate the count.
  always_comb begin
    chb      = CH_W'(sa_q.ch);
    x_b      = DATA_W'(sa_q.data);
    old_b    = ram_rdata;
    x_e      = ACC_W'(x_b);
    old_e    = ACC_W'(old_b);
    cnt_b    = count_q[chb];
    sum_b    = sum_q[chb];
    win_full = (cnt_b == n_cur);
    sum_n    = sum_b + x_e - (win_full ? old_e : '0);
    cnt_n    = win_full ? n_cur : cnt_b + CNT_W'(1);
    avg      = sum_n >>> sel_q;
  end

  // Next-state of per-channel state and registered outputs.
  always_comb begin
    wptr_d    = wptr_q;
    count_d   = count_q;
    sum_d     = sum_q;
    o_valid_d = sa_q.valid;
    o_ch_d    = o_ch_q;
    o_data_d  = o_data_q;
    o_full_d  = o_full_q;
    m_count_d = m_count_q;
    m_sum_d   = m_sum_q;
    if (accept) wptr_d[ch_a] = wptr_q[ch_a] + PTR_W'(1);
    if (sa_q.valid) begin
      sum_d[chb]   = sum_n;
      count_d[chb] = cnt_n;
      o_ch_d       = chb;
      o_data_d     = DATA_W'(avg);
      o_full_d     = (cnt_n == n_cur);
      m_count_d    = 16'(cnt_n);
      m_sum_d      = 64'(sum_n);
    end
    if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_d[c]  = '0;
        count_d[c] = '0;
        sum_d[c]   = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_q     <= '0;
      sa_q      <= '0;
      o_valid_q <= 1'b0;
      o_ch_q    <= '0;
      o_data_q  <= '0;
      o_full_q  <= 1'b0;
      m_count_q <= '0;
      m_sum_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= '0;
        count_q[c] <= '0;
        sum_q[c]   <= '0;
      end
    end else begin
      sel_q     <= sel_d;
      sa_q      <= sa_d;
      o_valid_q <= o_valid_d;
      o_ch_q    <= o_ch_d;
      o_data_q  <= o_data_d;
      o_full_q  <= o_full_d;
      m_count_q <= m_count_d;
      m_sum_q   <= m_sum_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_q[c]  <= wptr_d[c];
        count_q[c] <= count_d[c];
        sum_q[c]   <= sum_d[c];
      end
    end
  end

  assign o_valid = o_valid_q;
  assign o_ch    = o_ch_q;
  assign o_data  = o_data_q;
  assign o_full  = o_full_q;
  assign m_count = m_count_q;
  assign m_sum   = m_sum_q;

endmodule

// File: tb/tb_sma_mc.sv
// Directed bench for sma_mc.
// Hand-computed averages checked with immediate assertions.
module tb_sma_mc;

  logic clk = 1'b0;
  logic rst_n;
  logic stb;
  logic [1:0] ch;
  logic signed [31:0] data;
  logic [31:0] wsel;
  logic clr;
  logic o_valid;
  logic [1:0] o_ch;
  logic signed [31:0] o_data;
  logic o_full;
  logic [15:0] m_count;
  logic signed [63:0] m_sum;

  int checks = 0;
  int failures = 0;

  int dch [13] = '{0, 0, 1, 2, 0, 1, 1, 2, 0, 0, 2, 1, 1};
  int ddt [13] = '{10, 20, -100, 1000, 30, -200, -300,
                   2000, 40, 50, 3000, -400, -500};
  int eav [13] = '{2, 7, -25, 250, 15, -75, -150,
                   750, 25, 35, 1500, -250, -350};
  int efl [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1};
  int ecn [13] = '{1, 2, 1, 1, 3, 2, 3, 2, 4, 4, 3, 4, 4};

  sma_mc dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_update_strobe (stb),
    .i_ch            (ch),
    .i_data          (data),
    .i_window_sel    (wsel),
    .i_clear         (clr),
    .o_valid         (o_valid),
    .o_ch            (o_ch),
    .o_data          (o_data),
    .o_full          (o_full),
    .m_count         (m_count),
    .m_sum           (m_sum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint got,
                       input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input int ech,
                     input longint ed, input int ef, input int ec);
    check({tag, "_valid"}, longint'(o_valid), 1);
    check({tag, "_ch"}, longint'(o_ch), longint'(ech));
    check({tag, "_data"}, longint'(o_data), ed);
    check({tag, "_full"}, longint'(o_full), longint'(ef));
    check({tag, "_count"}, longint'(m_count), longint'(ec));
  endtask

  task automatic drv(input int c, input int d);
    stb  = 1'b1;
    ch   = 2'(c);
    data = d;
  endtask

  task automatic idle();
    stb  = 1'b0;
    ch   = '0;
    data = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    wsel  = 0;
    idle();
    tick();
    tick();
    check("rst_valid", longint'(o_valid), 0);
    check("rst_data", longint'(o_data), 0);
    check("rst_full", longint'(o_full), 0);
    check("rst_count", longint'(m_count), 0);
    check("rst_sum", m_sum, 0);
    check("rst_ch", longint'(o_ch), 0);
    rst_n = 1'b1;
    tick();

    // N=4 ramp on channel 0
    wsel = 2;
    tick();
    drv(0, 4);  tick();
    check("a_lat", longint'(o_valid), 0);
    drv(0, 8);  tick(); chk("a0", 0, 1, 0, 1);
    drv(0, 12); tick(); chk("a1", 0, 3, 0, 2);
    drv(0, 16); tick(); chk("a2", 0, 6, 0, 3);
    drv(0, 20); tick(); chk("a3", 0, 10, 1, 4);
    check("a3_sum", m_sum, 40);
    idle();     tick(); chk("a4", 0, 14, 1, 4);
    check("a4_sum", m_sum, 56);
    tick();
    check("a_width", longint'(o_valid), 0);

    // N=2 floor rounding on negatives
    wsel = 1;
    tick();
    drv(0, -3); tick();
    drv(0, -3); tick(); chk("b0", 0, -2, 0, 1);
    drv(0, -4); tick(); chk("b1", 0, -3, 1, 2);
    idle();     tick(); chk("b2", 0, -4, 1, 2);
    check("b2_sum", m_sum, -7);

    // N=64: read and write hit the same slot
    wsel = 6;
    tick();
    for (int i = 0; i < 66; i++) begin
      drv(0, (i < 64) ? 100 : 0);
      tick();
      if (i == 64) chk("c63", 0, 100, 1, 64);
      if (i == 65) chk("c64", 0, 98, 1, 64);
    end
    idle(); tick(); chk("c65", 0, 96, 1, 64);
    check("c65_sum", m_sum, 6200);

    // interleaved channels, N=4
    wsel = 2;
    clr  = 1'b1;
    tick();
    clr  = 1'b0;
    for (int k = 0; k < 13; k++) begin
      drv(dch[k], ddt[k]);
      tick();
      if (k > 0)
        chk($sformatf("d%0d", k - 1), dch[k - 1], eav[k - 1],
            efl[k - 1], ecn[k - 1]);
    end
    idle(); tick(); chk("d12", 1, -350, 1, 4);
    check("d12_sum", m_sum, -1400);
    drv(3, 777); tick();
    idle();      tick();
    check("d_badch", longint'(o_valid), 0);

    // window change with a strobe on the change cycle
    drv(0, 60); tick();
    wsel = 1;
    drv(0, 70); tick(); chk("e_old", 0, 45, 1, 4);
    idle();     tick();
    check("e_drop", longint'(o_valid), 0);
    drv(0, 9);  tick();
    idle();     tick(); chk("e_new", 0, 4, 0, 1);
    check("e_new_sum", m_sum, 9);

    // oversize selection clamps to 6
    wsel = 40;
    tick();
    drv(0, 128); tick();
    wsel = 6;
    drv(0, 64);  tick(); chk("f0", 0, 2, 0, 1);
    check("f0_sum", m_sum, 128);
    idle();      tick(); chk("f1", 0, 3, 0, 2);

    // explicit clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drv(0, 100); tick();
    idle();      tick(); chk("g0", 0, 1, 0, 1);
    check("g0_sum", m_sum, 100);

    // reset with samples in flight
    drv(0, 1000); tick();
    drv(0, 1000); tick(); chk("h0", 0, 17, 0, 2);
    rst_n = 1'b0;
    #1;
    check("h_rst_valid", longint'(o_valid), 0);
    check("h_rst_data", longint'(o_data), 0);
    check("h_rst_sum", m_sum, 0);
    check("h_rst_count", longint'(m_count), 0);
    idle();
    wsel = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check("h_lost0", longint'(o_valid), 0);
    tick();
    check("h_lost1", longint'(o_valid), 0);
    drv(0, 7); tick();
    drv(0, 9); tick(); chk("h1", 0, 7, 1, 1);
    idle();    tick(); chk("h2", 0, 9, 1, 1);
    check("h2_sum", m_sum, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sma_mc.md
# sma_mc

Multi-channel, time-multiplexed simple moving average for the FOG/PIG post-processing chain. It generalises the single-channel fixed-window SMA to NUM_CH independent channels sharing one pipeline and one ring-buffer RAM. The power-of-two window is selectable at run time up to 2^MAX_LOG2_WIN. Each channel reports a window-filled flag, and the block flushes cleanly on window change or explicit clear.

## Interface
- DATA_W, 32, signed sample width
- NUM_CH, 3, channel count (≥1)
- MAX_LOG2_WIN, 6, log2 of maximum window (max window 64)
- CH_W, $clog2(NUM_CH) min 1, channel index width (derived)
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; asynchronous, active-low
- i_update_strobe  in  1  sample valid, one sample per cycle max
- i_ch  in  CH_W  channel of current sample; values ≥NUM_CH are ignored (sample dropped)
- i_data  in  DATA_W  signed sample
- i_window_sel  in  32  log2 window; values >MAX_LOG2_WIN clamp to MAX_LOG2_WIN
- i_clear  in  1  flush all channel state
- o_valid  out  1  output strobe
- o_ch  out  CH_W  channel of o_data
- o_data  out  DATA_W  signed average
- o_full  out  1  channel window filled (count == N) after this sample
- m_count  out  16  fill count of channel in o_ch
- m_sum  out  64  sign-extended accumulator of channel in o_ch

## Operation
- L = clamped sel_q, N = 2^L. sel_q is a register holding the applied selection.
- Per channel: wptr[MAX_LOG2_WIN], count (saturates at N), and sum (signed, DATA_W+MAX_LOG2_WIN bits; cannot overflow).
- Stage A, cycle of strobe:
  - write i_data at {ch, wptr}
  - read {ch, wptr−N mod 2^MAX_LOG2_WIN}
  - wptr++ (wraps)
- Stage B:
  - sum' = sum + x − (count==N ? old : 0)
  - count' = min(count+1, N)
  - register o_data = sum' >>> L (arithmetic, floor toward −∞), then truncate to DATA_W (always fits)
  - o_full = (count'==N); o_valid, o_ch, m_count, m_sum
- During warm-up, empty slots count as zero; o_data = sum >>> L, o_full=0.
- Same channel back-to-back: stage B writes sum/count at end of cycle and the next stage B reads the updated values. No stall; throughput 1 sample/cycle.
- Flush event F = i_clear, or clamp(i_window_sel) ≠ sel_q. On cycle F:
  - i_update_strobe is dropped
  - sel_q updates
  - a sample already in stage B still emits its output using the old window
  - all wptr/count/sum are cleared at end of F; the clear overrides that stage B update
  - the first strobe after F starts a fresh window
- When N = 2^MAX_LOG2_WIN, read and write addresses coincide. The RAM must return old data on same-address read-during-write.

## Timing
- Latency: o_valid exactly 2 cycles after the accepted strobe, one cycle wide, in order.
- Reset values: o_valid=0, o_ch=0, o_data=0, o_full=0, m_count=0, m_sum=0, sel_q=0 (N=1); all channel state is 0.
- Reset mid-operation: in-flight samples are lost and no output is produced for them. RAM contents need not be cleared because count gates subtraction.
- Changing i_window_sel costs one dropped strobe slot plus a full refill of N samples before o_full.

## Structure
- Package sma_pkg holds:
  - clamp_log2(sel, max) function
  - accumulator width function ACC_W = DATA_W+MAX_LOG2_WIN
  - pipeline stage record typedef (valid, ch, data)
- Sub-module sma_ring_ram:
  - simple dual-port, depth NUM_CH·2^MAX_LOG2_WIN, width DATA_W
  - registered read, old-data on collision
  - no reset on the array
- Per-channel state lives in register arrays indexed by channel inside sma_mc.

## Test plan
- NUM_CH=1, sel=2, strobes 4,8,12,16,20 → o_data 1,3,6,10,14; o_full=1 from 4th output; each o_valid 2 cycles after its strobe.
- sel=1, samples −3,−3,−4 → o_data −2 (−3>>>1), −3, −4 (−7>>>1 = −4); checks floor rounding.
- sel=6 (N=64, collision case), 64×100 then 0 → 64th output 100, next output 98 (6300>>>6), subsequent outputs decline by 100/64 per step with floor.
- NUM_CH=3, continuous strobes ch 0,0,1,2,0,… with distinct ramps → each channel matches an independent software model; back-to-back same-channel updates are correct.
- Mid-stream sel 2→1 with strobe on the change cycle → that strobe is dropped, the in-flight output uses N=4, counts restart, first new output = x/2; i_window_sel=40 behaves as 6.
- Assert i_rst_n low with 2 samples in flight → all outputs 0 immediately, no o_valid after release, and the first post-reset window behaves as from power-up.
